// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard inputs from ID/EX/IMEM and PC, IF/ID and ID/EX controls back to the pipeline.
interface pipeline_hazard_ctrl_if;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       ex_mem_read;
    logic [4:0] ex_rd;
    logic       ex_redirect;
    logic       imem_ready;
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_bubble;
    logic [1:0] state_o;
    modport master (
        output id_rs1, id_rs2, ex_mem_read, ex_rd, ex_redirect, imem_ready,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, state_o
    );
    modport slave (
        input  id_rs1, id_rs2, ex_mem_read, ex_rd, ex_redirect, imem_ready,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, state_o
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: PC / IF/ID advance-hold-flush and ID/EX bubble control for load-use, redirect and imem wait.
// Optional saturating performance counters when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0]      lu_stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic [CNT_W-1:0]      imem_wait_cnt,
`endif
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int FW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;
    typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, IMEM_WAIT = 2'd2} state_t;
    state_t state, state_n;
    logic [FW-1:0] fcnt, fcnt_n;
    logic lu, do_redir, do_lu, do_miss, do_norm, in_flush;
    assign lu = bus.ex_mem_read && bus.ex_rd != 5'd0 && (bus.ex_rd == bus.id_rs1 || bus.ex_rd == bus.id_rs2);
    // ID holds a NOP while flushing, so lu only matters outside FLUSH
    assign do_redir = bus.ex_redirect;
    assign in_flush = !do_redir && state == FLUSH;
    assign do_lu    = !do_redir && state != FLUSH && lu;
    assign do_miss  = !do_redir && state != FLUSH && !lu && !bus.imem_ready;
    assign do_norm  = !do_redir && state != FLUSH && !lu && bus.imem_ready;
    always_comb begin
        bus.pc_write     = !rst && (do_redir || do_norm || (in_flush && bus.imem_ready));
        bus.if_id_write  = !rst && !do_lu;
        bus.if_id_flush  = rst || do_redir || in_flush || do_miss;
        bus.id_ex_bubble = rst || do_redir || do_lu;
        bus.state_o      = state;
        state_n = do_redir ? (FLUSH_CYCLES > 1 ? FLUSH : RUN) :
                  in_flush ? ((bus.imem_ready && fcnt == FW'(1)) ? RUN : FLUSH) :
                  do_lu    ? state :
                  do_miss  ? IMEM_WAIT : RUN;
        fcnt_n  = do_redir ? FW'(FLUSH_CYCLES - 1) :
                  (in_flush && bus.imem_ready) ? fcnt - FW'(1) : fcnt;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            fcnt  <= '0;
        end else begin
            state <= state_n;
            fcnt  <= fcnt_n;
        end
    end
`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lu_stall_cnt  <= '0;
            flush_cnt     <= '0;
            imem_wait_cnt <= '0;
        end else begin
            if (do_lu && lu_stall_cnt != '1) lu_stall_cnt <= lu_stall_cnt + CNT_W'(1);
            if ((do_redir || in_flush) && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
            if (do_miss && imem_wait_cnt != '1) imem_wait_cnt <= imem_wait_cnt + CNT_W'(1);
        end
    end
`endif
endmodule
